// File: rtl/lr_car_detector.sv
// lr_car_detector: synchronizes and debounces the local-road loop sensor, counts waiting cars, and requests service.
// Define LR_DET_MONITOR_EN to enable the sticky illegal-light monitor on light_err.
module lr_car_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_raw,
    input  logic [2:0]       hw_light,
    input  logic [2:0]       lr_light,
    output logic             lr_has_car,
    output logic [CNT_W-1:0] car_count,
    output logic             light_err
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, WAIT, SERVE, CLEAR} state_t;
    state_t state_q, state_d;
    logic sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d, filt_prev_q, has_q, has_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic arrival, lr_ok, lr_green, lr_yellow, lr_red;
    always_comb begin
        sync1_d = sensor_raw;
        sync2_d = sync1_q;
        filt_d = filt_q;
        deb_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_q == DW'(DEBOUNCE_CYCLES - 1))
                filt_d = sync2_q;
            else
                deb_d = deb_q + 1'b1;
        end
        arrival = filt_q & ~filt_prev_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        lr_ok = $onehot(lr_light);
        lr_green = lr_light == 3'b100;
        lr_yellow = lr_light == 3'b010;
        lr_red = lr_light == 3'b001;
        state_d = state_q;
        cnt_d = cnt_q;
        // Illegal light codes freeze the tracker; green always wins over a same-cycle arrival.
        if (lr_ok) begin
            case (state_q)
                IDLE, WAIT: begin
                    if (lr_green) begin
                        state_d = SERVE;
                        cnt_d = '0;
                    end else if (arrival) begin
                        state_d = WAIT;
                        cnt_d = cnt_inc;
                    end
                end
                SERVE: state_d = lr_yellow ? CLEAR : SERVE;
                CLEAR: begin
                    cnt_d = arrival ? cnt_inc : cnt_q;
                    if (lr_red) state_d = (cnt_d != '0) ? WAIT : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        has_d = cnt_d != '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q <= 1'b0;
            filt_prev_q <= 1'b0;
            deb_q <= '0;
            state_q <= IDLE;
            cnt_q <= '0;
            has_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q <= filt_d;
            filt_prev_q <= filt_q;
            deb_q <= deb_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            has_q <= has_d;
        end
    end
    assign lr_has_car = has_q;
    assign car_count = cnt_q;
`ifdef LR_DET_MONITOR_EN
    logic err_q, err_d, lr_green_prev_q;
    always_comb begin
        err_d = err_q | !$onehot(hw_light) | !lr_ok
              | (hw_light != 3'b001 && lr_light != 3'b001)
              | (lr_green && !lr_green_prev_q && cnt_q == '0 && !arrival);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            lr_green_prev_q <= 1'b0;
        end else begin
            err_q <= err_d;
            lr_green_prev_q <= lr_green;
        end
    end
    assign light_err = err_q;
`else
    logic unused_hw;
    assign unused_hw = ^hw_light;
    assign light_err = 1'b0;
`endif
endmodule

// File: tb/tb_lr_car_detector.sv
// tb_lr_car_detector: directed checks of debounce latency, counting, serve/clear flow, saturation, reset and monitor.
module tb_lr_car_detector;
    logic clk = 1'b0, rst_n = 1'b0;
    logic sensor = 1'b0, sensor2 = 1'b0;
    logic [2:0] hw = 3'b100, lr = 3'b001, hw2 = 3'b100, lr2 = 3'b001;
    logic has, has2, err, err2;
    logic [3:0] cnt;
    logic [1:0] cnt2;
    int checks = 0, errors = 0;
    bit exp_err;

    always #5 clk = ~clk;

    lr_car_detector dut (
        .clk(clk), .rst_n(rst_n), .sensor_raw(sensor), .hw_light(hw), .lr_light(lr),
        .lr_has_car(has), .car_count(cnt), .light_err(err)
    );
    lr_car_detector #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sensor_raw(sensor2), .hw_light(hw2), .lr_light(lr2),
        .lr_has_car(has2), .car_count(cnt2), .light_err(err2)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sensor = 1'b0;
        sensor2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic car(input bit second);
        @(negedge clk);
        if (second) sensor2 = 1'b1; else sensor = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        if (second) sensor2 = 1'b0; else sensor = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (has !== 1'b0 || cnt !== 4'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: has=%b cnt=%0d err=%b expected 0 0 0", has, cnt, err);
        end
    endtask

    task automatic test_first_car();
        do_reset();
        sensor = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd0 || has !== 1'b0) begin
            errors++;
            $display("FAIL first_car_edge6: cnt=%0d has=%b expected 0 0", cnt, has);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd1 || has !== 1'b1) begin
            errors++;
            $display("FAIL first_car_edge7: cnt=%0d has=%b expected 1 1", cnt, has);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        sensor = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_glitch();
        do_reset();
        sensor = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sensor = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd0 || has !== 1'b0) begin
            errors++;
            $display("FAIL glitch: cnt=%0d has=%b expected 0 0", cnt, has);
        end
    endtask

    task automatic test_serve();
        do_reset();
        repeat (3) car(1'b0);
        #1;
        checks++;
        if (cnt !== 4'd3 || has !== 1'b1) begin
            errors++;
            $display("FAIL three_cars: cnt=%0d has=%b expected 3 1", cnt, has);
        end
        @(negedge clk);
        hw = 3'b001;
        lr = 3'b100;
        checks++;
        if (cnt !== 4'd3) begin
            errors++;
            $display("FAIL pre_green: cnt=%0d expected 3", cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd0 || has !== 1'b0) begin
            errors++;
            $display("FAIL green_entry: cnt=%0d has=%b expected 0 0", cnt, has);
        end
        car(1'b0);
        #1;
        checks++;
        if (cnt !== 4'd0 || has !== 1'b0) begin
            errors++;
            $display("FAIL car_in_green: cnt=%0d has=%b expected 0 0", cnt, has);
        end
        @(negedge clk);
        lr = 3'b010;
        car(1'b0);
        #1;
        checks++;
        if (cnt !== 4'd1) begin
            errors++;
            $display("FAIL car_in_yellow: cnt=%0d expected 1", cnt);
        end
        @(negedge clk);
        lr = 3'b001;
        @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd1 || has !== 1'b1) begin
            errors++;
            $display("FAIL back_to_red: cnt=%0d has=%b expected 1 1", cnt, has);
        end
        @(negedge clk);
        hw = 3'b100;
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (3) car(1'b1);
        #1;
        checks++;
        if (cnt2 !== 2'd3 || has2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_three: cnt=%0d has=%b expected 3 1", cnt2, has2);
        end
        repeat (2) car(1'b1);
        #1;
        checks++;
        if (cnt2 !== 2'd3 || has2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_five: cnt=%0d has=%b expected 3 1", cnt2, has2);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2) car(1'b0);
        #1;
        checks++;
        if (cnt !== 4'd2) begin
            errors++;
            $display("FAIL pre_reset_count: cnt=%0d expected 2", cnt);
        end
        @(negedge clk);
        sensor = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt !== 4'd0 || has !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d has=%b expected 0 0", cnt, has);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_edge6: cnt=%0d expected 0", cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'd1 || has !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_edge7: cnt=%0d has=%b expected 1 1", cnt, has);
        end
        @(negedge clk);
        sensor = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_light_err();
`ifdef LR_DET_MONITOR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_before: err=%b expected 0", err);
        end
        hw = 3'b100;
        lr = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_set: err=%b expected %b", err, exp_err);
        end
        @(negedge clk);
        lr = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_sticky: err=%b expected %b", err, exp_err);
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: err=%b expected 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_first_car();
        test_glitch();
        test_serve();
        test_saturation();
        test_async_reset();
        test_light_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
